// File: rtl/softmax_driver_pkg.sv
// Shared widths, phase encoding and lane helper for the softmax operand/result driver.
package softmax_driver_pkg;

  localparam int DATAWIDTH = 16;
  localparam int NUM       = 4;
  localparam int PH_W      = 3;

  typedef logic [PH_W-1:0] phase_t;

  // Phase values track the softmax datapath's internal step counter.
  localparam phase_t PH_IDLE   = 3'd0;
  localparam phase_t PH_MAX    = 3'd1;
  localparam phase_t PH_SUB    = 3'd2;
  localparam phase_t PH_PRESUB = 3'd5;
  localparam phase_t PH_CAPT   = 3'd7;

  function automatic logic [DATAWIDTH-1:0] lane(input logic [DATAWIDTH*NUM-1:0] v, input int i);
    return v[DATAWIDTH*i +: DATAWIDTH];
  endfunction

endpackage

// File: rtl/softmax_in_fifo.sv
// Two-entry in-order vector buffer ahead of the softmax launch point.
module softmax_in_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_push = push && (count_q != 2'd2);
  assign do_pop  = pop && (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/softmax_driver.sv
// Feeds buffered vectors into the 4-lane softmax phase by phase and returns its results on a stream.
module softmax_driver
  import softmax_driver_pkg::*;
#(
  parameter int DATAWIDTH = softmax_driver_pkg::DATAWIDTH,
  parameter int NUM       = softmax_driver_pkg::NUM,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATAWIDTH*NUM-1:0] s_data,
  output logic                     sm_start,
  output logic [DATAWIDTH*NUM-1:0] sm_inp,
  output logic [DATAWIDTH*NUM-1:0] sm_sub0_inp,
  output logic [DATAWIDTH*NUM-1:0] sm_sub1_inp,
  input  logic [DATAWIDTH-1:0]     sm_outp0,
  input  logic [DATAWIDTH-1:0]     sm_outp1,
  input  logic [DATAWIDTH-1:0]     sm_outp2,
  input  logic [DATAWIDTH-1:0]     sm_outp3,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATAWIDTH*NUM-1:0] m_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int VW = DATAWIDTH*NUM;

  phase_t           phase_q, phase_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic             m_valid_q, m_valid_d;
  logic [VW-1:0]    m_data_q, m_data_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             fifo_push;
  logic [VW-1:0]    fifo_dout;
  logic [1:0]       fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  assign s_ready   = (fifo_count != 2'd2);
  assign fifo_push = s_valid && !fifo_full;

  softmax_in_fifo #(.W(VW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (sm_start),
    .din   (s_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Launch only into an empty result slot so a capture can never overwrite a pending result.
  assign sm_start = (phase_q == PH_IDLE) && !fifo_empty && !m_valid_q;

  always_comb begin
    phase_d    = phase_q;
    vec_d      = vec_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    op_count_d = op_count_q;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    if (sm_start) begin
      vec_d   = fifo_dout;
      phase_d = PH_MAX;
    end else if (phase_q == PH_CAPT) begin
      m_data_d   = {sm_outp3, sm_outp2, sm_outp1, sm_outp0};
      m_valid_d  = 1'b1;
      op_count_d = op_count_q + 1'b1;
      phase_d    = PH_IDLE;
    end else if (phase_q != PH_IDLE) begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= PH_IDLE;
      vec_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      op_count_q <= '0;
    end else begin
      phase_q    <= phase_d;
      vec_q      <= vec_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      op_count_q <= op_count_d;
    end
  end

  // Each operand bus carries the vector only in the phase the datapath samples it.
  assign sm_inp      = (phase_q == PH_MAX)    ? vec_q : '0;
  assign sm_sub0_inp = (phase_q == PH_SUB)    ? vec_q : '0;
  assign sm_sub1_inp = (phase_q == PH_PRESUB) ? vec_q : '0;

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign busy     = (phase_q != PH_IDLE);
  assign op_count = op_count_q;

endmodule
